game_ctrl: RTL and testbench

Round-sequencing controller for the Pong datapath. It derives a once-per-frame tick from the VGA scan position and runs the match state machine: idle, serve countdown, play, point pause, game over. It keeps both scores and drives the enable and reset strobes that gate the paddle and ball blocks. It sits between the VGA sync counters, ball logic and paddle logic, and feeds the score/overlay renderer.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/frame_tick.sv | 34 +++
 rtl/game_ctrl.sv | 150 +++++++++++++++
 tb/tb_game_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: match states, winner codes and screen geometry.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  localparam int unsigned TICK_Y_DEF = 481;
  localparam int unsigned X_MAX      = 639;
  localparam int unsigned Y_MAX      = 479;

endpackage

// File: rtl/frame_tick.sv
// One-cycle pulse per frame, taken from the first cycle the scan
// position sits on (x == 0, y == TICK_Y).
import pong_pkg::*;

module frame_tick #(
  parameter int unsigned TICK_Y = TICK_Y_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       tick_o
);

  logic hit_d;
  logic hit_q;
  logic hit_prev_q;

  assign hit_d = (y_i == 10'(TICK_Y)) && (x_i == 10'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q      <= 1'b0;
      hit_prev_q <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      hit_prev_q <= hit_q;
    end
  end

  // x may rest at 0 for several clocks; only the first one counts
  assign tick_o = hit_q & ~hit_prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Pong match sequencer: frame-timed serve and point pauses, scoring,
// and the enable/reset strobes for the paddle and ball blocks.
import pong_pkg::*;

module game_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned TICK_Y       = TICK_Y_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic       pad_en,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [1:0] win_q, win_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q;
  logic       pad_en_q, pad_en_d;
  logic       ball_en_q, ball_en_d;
  logic       ball_rst_q, ball_rst_d;
  logic       tick;
  logic       start_edge;

  frame_tick #(
    .TICK_Y (TICK_Y)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .x_i    (x),
    .y_i    (y),
    .tick_o (tick)
  );

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d = ST_SERVE;
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          win_d   = WIN_NONE;
          cnt_d   = 8'(SERVE_FRAMES);
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == 8'd1) state_d = ST_PLAY;
          else cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PLAY: begin
        if (miss1 || miss2) begin
          state_d = ST_POINT;
          cnt_d   = 8'(POINT_FRAMES);
        end
        // simultaneous misses replay the point with no score
        if (miss1 && !miss2) begin
          s2_d  = s2_q + 4'd1;
          dir_d = 1'b1;
          if (s2_d == 4'(WIN_SCORE)) begin
            state_d = ST_OVER;
            win_d   = WIN_P2;
          end
        end else if (miss2 && !miss1) begin
          s1_d  = s1_q + 4'd1;
          dir_d = 1'b0;
          if (s1_d == 4'(WIN_SCORE)) begin
            state_d = ST_OVER;
            win_d   = WIN_P1;
          end
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (cnt_q == 8'd1) begin
            state_d = ST_SERVE;
            cnt_d   = 8'(SERVE_FRAMES);
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pad_en_d   = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    ball_en_d  = (state_d == ST_PLAY);
    ball_rst_d = (state_d != ST_PLAY) && (state_d != ST_POINT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s1_q       <= 4'd0;
      s2_q       <= 4'd0;
      win_q      <= WIN_NONE;
      dir_q      <= 1'b0;
      cnt_q      <= 8'd0;
      start_q    <= 1'b0;
      pad_en_q   <= 1'b0;
      ball_en_q  <= 1'b0;
      ball_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      win_q      <= win_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      start_q    <= start;
      pad_en_q   <= pad_en_d;
      ball_en_q  <= ball_en_d;
      ball_rst_q <= ball_rst_d;
    end
  end

  assign state     = state_q;
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign winner    = win_q;
  assign serve_dir = dir_q;
  assign pad_en    = pad_en_q;
  assign ball_en   = ball_en_q;
  assign ball_rst  = ball_rst_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus a random run
// checked against a frame-level model of the match rules.
module tb_game_ctrl;

  localparam int WIN = 4;
  localparam int SF  = 3;
  localparam int PF  = 2;
  localparam int TY  = 481;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       start, miss1, miss2;
  logic       pad_en, ball_en, ball_rst, serve_dir;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // model: match phase, scores by player, frames left in a pause
  int m_state;
  int m_score [1:2];
  int m_win;
  int m_dir;
  int m_left;
  bit c1, c2, st_prev;

  game_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF),
    .TICK_Y       (TY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .start     (start),
    .miss1     (miss1),
    .miss2     (miss2),
    .pad_en    (pad_en),
    .ball_en   (ball_en),
    .ball_rst  (ball_rst),
    .serve_dir (serve_dir),
    .score1    (score1),
    .score2    (score2),
    .winner    (winner),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    m_score[1] = 0;
    m_score[2] = 0;
    m_win = 0;
    m_dir = 0;
    m_left = 0;
    c1 = 0;
    c2 = 0;
    st_prev = 0;
  endtask

  task automatic model_edge();
    bit tick, se, cond;
    int p;
    tick = c1 && !c2;
    se   = start && !st_prev;
    cond = (y == 10'(TY)) && (x == 10'd0);
    if (reset) begin
      model_reset();
      return;
    end
    case (m_state)
      0, 4: if (se) begin
        m_state = 1;
        m_score[1] = 0;
        m_score[2] = 0;
        m_win = 0;
        m_left = SF;
      end
      1: if (tick) begin
        m_left--;
        if (m_left == 0) m_state = 2;
      end
      2: if (miss1 && miss2) begin
        m_state = 3;
        m_left = PF;
      end else if (miss1 || miss2) begin
        p = miss2 ? 1 : 2;
        m_score[p]++;
        m_dir = miss1 ? 1 : 0;
        if (m_score[p] == WIN) begin
          m_state = 4;
          m_win = p;
        end else begin
          m_state = 3;
          m_left = PF;
        end
      end
      3: if (tick) begin
        m_left--;
        if (m_left == 0) begin
          m_state = 1;
          m_left = SF;
        end
      end
      default: m_state = 0;
    endcase
    c2 = c1;
    c1 = cond;
    st_prev = start;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic frame();
    x = 10'd0;
    y = 10'(TY);
    step();
    x = 10'd7;
    step();
    step();
    y = 10'd0;
  endtask

  task automatic between_points();
    repeat (PF) frame();
    repeat (SF) frame();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x = 10'd7;
    y = 10'd0;
    start = 0;
    miss1 = 0;
    miss2 = 0;
    model_reset();
    #12;
    checks++;
    if ({state, score1, score2, winner, serve_dir,
         pad_en, ball_en, ball_rst} !==
        {3'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_vals st=%0d s1=%0d s2=%0d w=%0d rst=%0b",
               state, score1, score2, winner, ball_rst);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_serve();
    start = 1;
    step();
    start = 0;
    checks++;
    if ({state, pad_en, ball_en, ball_rst} !== {3'd1, 3'b101}) begin
      errors++;
      $display("FAIL serve_entry st=%0d pad=%0b ball=%0b rst=%0b exp 1/1/0/1",
               state, pad_en, ball_en, ball_rst);
    end
    frame();
    frame();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL serve_2ticks st=%0d exp 1", state);
    end
    frame();
    checks++;
    if ({state, pad_en, ball_en, ball_rst} !== {3'd2, 3'b110}) begin
      errors++;
      $display("FAIL serve_to_play st=%0d pad=%0b ball=%0b rst=%0b exp 2/1/1/0",
               state, pad_en, ball_en, ball_rst);
    end
  endtask

  task automatic test_point();
    miss1 = 1;
    step();
    miss1 = 0;
    checks++;
    if ({state, score1, score2, serve_dir, pad_en, ball_rst} !==
        {3'd3, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL point_miss1 st=%0d s1=%0d s2=%0d dir=%0b pad=%0b rst=%0b",
               state, score1, score2, serve_dir, pad_en, ball_rst);
    end
    frame();
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL point_hold st=%0d exp 3", state);
    end
    frame();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL point_to_serve st=%0d exp 1", state);
    end
    repeat (SF) frame();
  endtask

  task automatic test_both_miss();
    miss1 = 1;
    miss2 = 1;
    step();
    miss1 = 0;
    miss2 = 0;
    checks++;
    if ({state, score1, score2, serve_dir} !==
        {3'd3, 4'd0, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL both_miss st=%0d s1=%0d s2=%0d dir=%0b exp 3/0/1/1",
               state, score1, score2, serve_dir);
    end
    between_points();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      miss2 = 1;
      step();
      miss2 = 0;
      if (i < 2) between_points();
    end
    checks++;
    if ({state, score1} !== {3'd3, 4'd3}) begin
      errors++;
      $display("FAIL pre_reset st=%0d s1=%0d exp 3/3", state, score1);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({state, score1, score2, ball_rst, pad_en} !==
        {3'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset st=%0d s1=%0d s2=%0d rst=%0b pad=%0b",
               state, score1, score2, ball_rst, pad_en);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_win();
    start = 1;
    step();
    start = 0;
    repeat (SF) frame();
    for (int i = 0; i < WIN; i++) begin
      if (i == WIN - 1) start = 1;
      miss2 = 1;
      step();
      miss2 = 0;
      if (i < WIN - 1) between_points();
    end
    checks++;
    if ({state, score1, winner, ball_rst} !==
        {3'd4, 4'(WIN), 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL win st=%0d s1=%0d w=%0d rst=%0b", state, score1,
               winner, ball_rst);
    end
    repeat (3) step();
    miss2 = 1;
    step();
    miss2 = 0;
    checks++;
    if ({state, score1} !== {3'd4, 4'(WIN)}) begin
      errors++;
      $display("FAIL over_hold st=%0d s1=%0d exp 4/%0d", state, score1, WIN);
    end
    start = 0;
    step();
    start = 1;
    step();
    start = 0;
    checks++;
    if ({state, score1, score2, winner} !== {3'd1, 4'd0, 4'd0, 2'd0}) begin
      errors++;
      $display("FAIL restart st=%0d s1=%0d s2=%0d w=%0d", state, score1,
               score2, winner);
    end
  endtask

  task automatic test_tick_hold();
    x = 10'd0;
    y = 10'(TY);
    repeat (4) step();
    x = 10'd7;
    step();
    step();
    y = 10'd0;
    frame();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL tick_hold st=%0d exp 1", state);
    end
    frame();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL tick_hold_play st=%0d exp 2", state);
    end
  endtask

  task automatic test_start_held();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1;
    step();
    miss1 = 1;
    step();
    miss1 = 0;
    checks++;
    if ({state, score1, score2} !== {3'd1, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL miss_in_serve st=%0d s1=%0d s2=%0d", state, score1,
               score2);
    end
    repeat (SF) frame();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL start_held st=%0d exp 2", state);
    end
    start = 0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      miss1 = ($urandom_range(0, 9) == 0);
      miss2 = ($urandom_range(0, 9) == 0);
      y = ($urandom_range(0, 3) != 0) ? 10'(TY) : 10'($urandom_range(0, 479));
      x = 10'($urandom_range(0, 2));
      step();
      checks++;
      if ({state, score1, score2, winner, serve_dir,
           pad_en, ball_en, ball_rst} !==
          {3'(m_state), 4'(m_score[1]), 4'(m_score[2]), 2'(m_win),
           1'(m_dir), 1'(m_state == 1 || m_state == 2),
           1'(m_state == 2), 1'(m_state != 2 && m_state != 3)}) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand cyc=%0d st=%0d/%0d s1=%0d/%0d s2=%0d/%0d w=%0d/%0d",
                   i, state, m_state, score1, m_score[1], score2,
                   m_score[2], winner, m_win);
      end
    end
    start = 0;
    miss1 = 0;
    miss2 = 0;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point();
    test_both_miss();
    test_async_reset();
    test_win();
    test_tick_hold();
    test_start_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
